// File: rtl/ccip_c0_rd_arbiter.sv
// ccip_c0_rd_arbiter: round-robin arbiter for two CCI-P channel-0 read requesters
// Shares the c0 read-request path between two requesters in the pClkDiv2 AFU domain.
// It respects c0tx almost-full and caps the number of outstanding reads. Each request is
// tagged with the requester ID in mdata[15], and responses are routed back by that bit.
// A drain handshake stops new grants until every outstanding read has been returned.
// Ports:
//   pClk, pck_cp2af_softReset          clock, synchronous active-high reset
//   rqN_valid/ready/addr/mdata         requester N request handshake (N=0,1)
//   c0tx_almfull, c0tx_valid/addr/mdata issued read request toward CCI-P
//   c0rx_rspvalid/mdata/data           read response from CCI-P
//   rspN_valid/mdata/data              routed response to requester N
//   drain_req, drain_done              quiesce handshake
//   outstanding, err_underflow         in-flight count, sticky underflow flag
//   stat0_grants, stat1_grants, stat_stall  statistics (built when C0_ARB_STATS_EN is defined)
// Optional feature macro: C0_ARB_STATS_EN
module ccip_c0_rd_arbiter #(
    parameter int MAX_OUTSTANDING = 64,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             pClk,
    input  logic             pck_cp2af_softReset,
    input  logic             rq0_valid,
    output logic             rq0_ready,
    input  logic [41:0]      rq0_addr,
    input  logic [14:0]      rq0_mdata,
    input  logic             rq1_valid,
    output logic             rq1_ready,
    input  logic [41:0]      rq1_addr,
    input  logic [14:0]      rq1_mdata,
    input  logic             c0tx_almfull,
    output logic             c0tx_valid,
    output logic [41:0]      c0tx_addr,
    output logic [15:0]      c0tx_mdata,
    input  logic             c0rx_rspvalid,
    input  logic [15:0]      c0rx_mdata,
    input  logic [511:0]     c0rx_data,
    output logic             rsp0_valid,
    output logic [14:0]      rsp0_mdata,
    output logic [511:0]     rsp0_data,
    output logic             rsp1_valid,
    output logic [14:0]      rsp1_mdata,
    output logic [511:0]     rsp1_data,
    input  logic             drain_req,
    output logic             drain_done,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_underflow,
    output logic [31:0]      stat0_grants,
    output logic [31:0]      stat1_grants,
    output logic [31:0]      stat_stall
);
    typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;
    state_t state;
    logic rrPtr;
    logic eligible, grant0, grant1, grant, rspTo0, rspTo1;
    // Gating with reset keeps ready low while reset is held.
    always_comb begin
        eligible = !pck_cp2af_softReset && state == RUN && !c0tx_almfull
                   && outstanding < CNT_W'(MAX_OUTSTANDING);
        grant0   = rq0_valid && eligible && (!rq1_valid || !rrPtr);
        grant1   = rq1_valid && eligible && (!rq0_valid || rrPtr);
        grant    = grant0 || grant1;
        rspTo0   = c0rx_rspvalid && !c0rx_mdata[15];
        rspTo1   = c0rx_rspvalid && c0rx_mdata[15];
    end
    assign rq0_ready = grant0;
    assign rq1_ready = grant1;
    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            state      <= RUN;
            drain_done <= 1'b0;
        end else begin
            case (state)
                RUN:     if (drain_req) state <= DRAIN;
                DRAIN:   if (outstanding == '0) begin
                             state      <= DRAINED;
                             drain_done <= 1'b1;
                         end
                DRAINED: if (!drain_req) begin
                             state      <= RUN;
                             drain_done <= 1'b0;
                         end
                default: state <= RUN;
            endcase
        end
    end
    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            rrPtr         <= 1'b0;
            c0tx_valid    <= 1'b0;
            c0tx_addr     <= '0;
            c0tx_mdata    <= '0;
            outstanding   <= '0;
            err_underflow <= 1'b0;
            rsp0_valid    <= 1'b0;
            rsp0_mdata    <= '0;
            rsp0_data     <= '0;
            rsp1_valid    <= 1'b0;
            rsp1_mdata    <= '0;
            rsp1_data     <= '0;
        end else begin
            // After any grant the pointer prefers the requester that did not win.
            if (grant) rrPtr <= grant0;
            c0tx_valid <= grant;
            if (grant) begin
                c0tx_addr  <= grant1 ? rq1_addr : rq0_addr;
                c0tx_mdata <= grant1 ? {1'b1, rq1_mdata} : {1'b0, rq0_mdata};
            end
            if (grant && !c0rx_rspvalid)
                outstanding <= outstanding + CNT_W'(1);
            else if (!grant && c0rx_rspvalid && outstanding != '0)
                outstanding <= outstanding - CNT_W'(1);
            if (c0rx_rspvalid && outstanding == '0) err_underflow <= 1'b1;
            rsp0_valid <= rspTo0;
            rsp1_valid <= rspTo1;
            if (rspTo0) begin
                rsp0_mdata <= c0rx_mdata[14:0];
                rsp0_data  <= c0rx_data;
            end
            if (rspTo1) begin
                rsp1_mdata <= c0rx_mdata[14:0];
                rsp1_data  <= c0rx_data;
            end
        end
    end
`ifdef C0_ARB_STATS_EN
    // Saturating counters; a stall is a pending request refused while running.
    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            stat0_grants <= '0;
            stat1_grants <= '0;
            stat_stall   <= '0;
        end else begin
            if (grant0 && stat0_grants != '1) stat0_grants <= stat0_grants + 32'd1;
            if (grant1 && stat1_grants != '1) stat1_grants <= stat1_grants + 32'd1;
            if (state == RUN && (rq0_valid || rq1_valid) && !eligible && stat_stall != '1)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`else
    assign stat0_grants = '0;
    assign stat1_grants = '0;
    assign stat_stall   = '0;
`endif
endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// tb_ccip_c0_rd_arbiter: directed and randomized self-checking bench for ccip_c0_rd_arbiter
module tb_ccip_c0_rd_arbiter;
    localparam int MAX = 4;
    localparam int CW = $clog2(MAX + 1);
    logic pClk = 1'b0;
    logic rst;
    logic rq0_valid, rq0_ready, rq1_valid, rq1_ready;
    logic [41:0] rq0_addr, rq1_addr;
    logic [14:0] rq0_mdata, rq1_mdata;
    logic almfull, c0tx_valid;
    logic [41:0] c0tx_addr;
    logic [15:0] c0tx_mdata;
    logic rspvalid;
    logic [15:0] rx_mdata;
    logic [511:0] rx_data;
    logic rsp0_valid, rsp1_valid;
    logic [14:0] rsp0_mdata, rsp1_mdata;
    logic [511:0] rsp0_data, rsp1_data;
    logic drain_req, drain_done, err_underflow;
    logic [CW-1:0] outstanding;
    logic [31:0] stat0_grants, stat1_grants, stat_stall;
    int compared = 0;
    int mismatched = 0;
    // Reference model state
    int mInflight;
    bit mPrefer1;
    int mMode;
    bit mErr;
    bit eTxV;
    logic [41:0] eTxA;
    logic [15:0] eTxM;
    bit eR0V, eR1V;
    logic [14:0] eR0M, eR1M;
    logic [511:0] eR0D, eR1D;
    longint eS0, eS1, eSt;
    bit lastG0, lastG1;
    logic [15:0] pend[$];

    always #5 pClk = ~pClk;

    ccip_c0_rd_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .pClk(pClk), .pck_cp2af_softReset(rst),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_addr(rq0_addr), .rq0_mdata(rq0_mdata),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_addr(rq1_addr), .rq1_mdata(rq1_mdata),
        .c0tx_almfull(almfull), .c0tx_valid(c0tx_valid), .c0tx_addr(c0tx_addr), .c0tx_mdata(c0tx_mdata),
        .c0rx_rspvalid(rspvalid), .c0rx_mdata(rx_mdata), .c0rx_data(rx_data),
        .rsp0_valid(rsp0_valid), .rsp0_mdata(rsp0_mdata), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_mdata(rsp1_mdata), .rsp1_data(rsp1_data),
        .drain_req(drain_req), .drain_done(drain_done), .outstanding(outstanding),
        .err_underflow(err_underflow), .stat0_grants(stat0_grants), .stat1_grants(stat1_grants),
        .stat_stall(stat_stall)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic newReq(input int n);
        if (n == 0) begin
            rq0_valid = 1'b1;
            rq0_addr  = 42'({$urandom(), $urandom()});
            rq0_mdata = 15'($urandom());
        end else begin
            rq1_valid = 1'b1;
            rq1_addr  = 42'({$urandom(), $urandom()});
            rq1_mdata = 15'($urandom());
        end
    endtask

    // Returns a random still-outstanding request, in any order.
    task automatic respond();
        int idx;
        if (pend.size() == 0) begin
            rspvalid = 1'b0;
            return;
        end
        idx = $urandom_range(0, pend.size() - 1);
        rx_mdata = pend[idx];
        pend.delete(idx);
        rspvalid = 1'b1;
        for (int i = 0; i < 16; i++) rx_data[i*32 +: 32] = $urandom();
    endtask

    // One clock: predict from the rules, check ready, then check registered outputs.
    task automatic cycle();
        bit elig, g0, g1;
        @(negedge pClk);
        elig = !rst && mMode == 0 && !almfull && mInflight < MAX;
        g0 = rq0_valid && elig && (!rq1_valid || !mPrefer1);
        g1 = rq1_valid && elig && !g0;
        chk("rq0_ready", rq0_ready, g0);
        chk("rq1_ready", rq1_ready, g1);
        lastG0 = g0;
        lastG1 = g1;
        if (rst) begin
            mInflight = 0; mPrefer1 = 0; mMode = 0; mErr = 0;
            eTxV = 0; eTxA = '0; eTxM = '0;
            eR0V = 0; eR1V = 0; eR0M = '0; eR1M = '0; eR0D = '0; eR1D = '0;
            eS0 = 0; eS1 = 0; eSt = 0;
            pend.delete();
        end else begin
            if (mMode == 0 && (rq0_valid || rq1_valid) && !elig && eSt < 64'hFFFFFFFF) eSt++;
            if (g0 && eS0 < 64'hFFFFFFFF) eS0++;
            if (g1 && eS1 < 64'hFFFFFFFF) eS1++;
            if (mMode == 0 && drain_req) mMode = 1;
            else if (mMode == 1 && mInflight == 0) mMode = 2;
            else if (mMode == 2 && !drain_req) mMode = 0;
            if (rspvalid && mInflight == 0) mErr = 1;
            if ((g0 || g1) && !rspvalid) mInflight++;
            else if (!(g0 || g1) && rspvalid && mInflight > 0) mInflight--;
            eTxV = g0 || g1;
            if (g0) begin eTxA = rq0_addr; eTxM = {1'b0, rq0_mdata}; mPrefer1 = 1; end
            if (g1) begin eTxA = rq1_addr; eTxM = {1'b1, rq1_mdata}; mPrefer1 = 0; end
            if (eTxV) pend.push_back(eTxM);
            eR0V = rspvalid && !rx_mdata[15];
            eR1V = rspvalid && rx_mdata[15];
            if (eR0V) begin eR0M = rx_mdata[14:0]; eR0D = rx_data; end
            if (eR1V) begin eR1M = rx_mdata[14:0]; eR1D = rx_data; end
        end
        @(posedge pClk);
        #1;
        chk("c0tx_valid", c0tx_valid, eTxV);
        if (eTxV) begin
            chk("c0tx_addr", c0tx_addr, eTxA);
            chk("c0tx_mdata", c0tx_mdata, eTxM);
        end
        chk("rsp0_valid", rsp0_valid, eR0V);
        chk("rsp1_valid", rsp1_valid, eR1V);
        if (eR0V) begin chk("rsp0_mdata", rsp0_mdata, eR0M); chk("rsp0_data", rsp0_data, eR0D); end
        if (eR1V) begin chk("rsp1_mdata", rsp1_mdata, eR1M); chk("rsp1_data", rsp1_data, eR1D); end
        chk("outstanding", outstanding, mInflight);
        chk("drain_done", drain_done, mMode == 2);
        chk("err_underflow", err_underflow, mErr);
`ifdef C0_ARB_STATS_EN
        chk("stat0_grants", stat0_grants, eS0);
        chk("stat1_grants", stat1_grants, eS1);
        chk("stat_stall", stat_stall, eSt);
`else
        chk("stat0_grants", stat0_grants, 0);
        chk("stat1_grants", stat1_grants, 0);
        chk("stat_stall", stat_stall, 0);
`endif
    endtask

    task automatic flush();
        while (pend.size() > 0) begin
            respond();
            cycle();
        end
        rspvalid = 1'b0;
        cycle();
    endtask

    initial begin
        logic [5:0] seq;
        longint stBase;
        rst = 1'b1; rq0_valid = 0; rq1_valid = 0; rq0_addr = '0; rq1_addr = '0;
        rq0_mdata = '0; rq1_mdata = '0; almfull = 0; rspvalid = 0; rx_mdata = '0;
        rx_data = '0; drain_req = 0;
        cycle();
        cycle();
        chk("rst_outstanding", outstanding, 0);
        chk("rst_c0tx_addr", c0tx_addr, 0);
        chk("rst_rsp0_data", rsp0_data, 0);
        rst = 1'b0;
        cycle();

        // Contention: both requesters hold valid for six cycles
        newReq(0);
        newReq(1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) respond(); else rspvalid = 1'b0;
            cycle();
            chk("cont_issue", c0tx_valid, 1);
            seq[i] = c0tx_mdata[15];
            if (lastG0) newReq(0);
            if (lastG1) newReq(1);
        end
        chk("cont_order", seq, 6'b101010);
        rq0_valid = 0; rq1_valid = 0;
        flush();

        // Single requester burst of four
        rq0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rq0_addr = 42'h100 + 42'(i);
            rq0_mdata = 15'(i);
            cycle();
            chk("burst_issue", c0tx_valid, 1);
            chk("burst_addr", c0tx_addr, 42'h100 + 42'(i));
            chk("burst_id", c0tx_mdata[15], 0);
        end
        rq0_valid = 1'b0;
        chk("burst_outstanding", outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            respond();
            cycle();
            chk("burst_rsp0", rsp0_valid, 1);
        end
        rspvalid = 1'b0;
        cycle();
        chk("burst_drained", outstanding, 0);

        // Backpressure
        almfull = 1'b1;
        newReq(1);
        stBase = eSt;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_ready", rq1_ready, 0);
        end
`ifdef C0_ARB_STATS_EN
        chk("bp_stall", stat_stall, stBase + 5);
`endif
        almfull = 1'b0;
        cycle();
        chk("bp_issue", c0tx_valid, 1);
        chk("bp_id", c0tx_mdata[15], 1);
        rq1_valid = 1'b0;
        flush();

        // Credit cap
        newReq(0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (lastG0) newReq(0);
        end
        chk("cap_outstanding", outstanding, MAX);
        chk("cap_held", rq0_ready, 0);
        respond();
        cycle();
        chk("cap_still_held", c0tx_valid, 0);
        respond();
        cycle();
        chk("cap_grant", c0tx_valid, 1);
        chk("cap_simul", outstanding, MAX - 1);
        rspvalid = 1'b0;
        rq0_valid = 1'b0;
        flush();

        // Drain
        newReq(0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            newReq(0);
        end
        rq0_valid = 1'b0;
        drain_req = 1'b1;
        cycle();
        newReq(0);
        cycle();
        chk("drain_no_ready", rq0_ready, 0);
        chk("drain_no_issue", c0tx_valid, 0);
        for (int i = 0; i < 3; i++) begin
            respond();
            cycle();
        end
        rspvalid = 1'b0;
        cycle();
        chk("drain_done_set", drain_done, 1);
        drain_req = 1'b0;
        cycle();
        chk("drain_exit_no_issue", c0tx_valid, 0);
        cycle();
        chk("drain_resume", c0tx_valid, 1);
        rq0_valid = 1'b0;
        flush();

        // Underflow
        rx_mdata = 16'h0005;
        rspvalid = 1'b1;
        cycle();
        rspvalid = 1'b0;
        chk("underflow_err", err_underflow, 1);
        chk("underflow_out", outstanding, 0);
        repeat (3) cycle();
        chk("underflow_sticky", err_underflow, 1);

        // Reset mid-burst
        newReq(0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            newReq(0);
        end
        rst = 1'b1;
        cycle();
        chk("rst_mid_c0tx_valid", c0tx_valid, 0);
        chk("rst_mid_outstanding", outstanding, 0);
        chk("rst_mid_err", err_underflow, 0);
        chk("rst_mid_ready", rq0_ready, 0);
        chk("rst_mid_c0tx_mdata", c0tx_mdata, 0);
        rst = 1'b0;
        rq0_valid = 1'b0;
        rx_mdata = 16'h8001;
        rspvalid = 1'b1;
        cycle();
        rspvalid = 1'b0;
        chk("rst_stale_underflow", err_underflow, 1);
        chk("rst_stale_rsp1", rsp1_valid, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            almfull = ($urandom_range(0, 4) == 0);
            if (lastG0 || !rq0_valid) begin
                if ($urandom_range(0, 1) == 1) newReq(0); else rq0_valid = 1'b0;
            end
            if (lastG1 || !rq1_valid) begin
                if ($urandom_range(0, 1) == 1) newReq(1); else rq1_valid = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) respond(); else rspvalid = 1'b0;
            if ($urandom_range(0, 59) == 0) drain_req = !drain_req;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ccip_c0_rd_arbiter.md
# ccip_c0_rd_arbiter

Round-robin arbiter sharing the AFU's CCI-P channel-0 read-request path between two requesters (e.g. image-source reader and descriptor reader) inside the pClkDiv2 AFU domain, behind the async shim. Enforces almost-full backpressure and a cap on outstanding reads. Tags each request with the requester ID in mdata[15], routes read responses back by that bit, and supports a drain/quiesce handshake for clean teardown.

## Interface
- MAX_OUTSTANDING, 64: maximum in-flight read requests; 1..32767.
- CNT_W, $clog2(MAX_OUTSTANDING+1): outstanding-counter width (derived, not overridden).
- pClk  in  1  AFU clock; all logic on rising edge.
- pck_cp2af_softReset  in  1  reset, synchronous, active-high.
- rqN_valid  in  1  (N=0,1) requester N has a read request.
- rqN_ready  out  1  request accepted this cycle (valid&&ready).
- rqN_addr  in  42  cache-line address.
- rqN_mdata  in  15  requester tag, returned with response.
- c0tx_almfull  in  1  CCI-P c0 TX almost-full.
- c0tx_valid  out  1  read request issue strobe.
- c0tx_addr  out  42  issued address.
- c0tx_mdata  out  16  {requester ID, rqN_mdata}.
- c0rx_rspvalid  in  1  read response valid.
- c0rx_mdata  in  16  response mdata.
- c0rx_data  in  512  response line.
- rspN_valid  out  1  response for requester N.
- rspN_mdata  out  15  returned tag.
- rspN_data  out  512  returned line.
- drain_req  in  1  level; stop granting and wait for all responses.
- drain_done  out  1  drained and idle.
- outstanding  out  CNT_W  in-flight count.
- err_underflow  out  1  sticky: response received with outstanding==0.
- statN_grants  out  32  grants to requester N (see Configuration).
- stat_stall  out  32  cycles with a pending request blocked by almfull or credit cap.

## Operation
- FSM: RUN, DRAIN, DRAINED. Reset -> RUN.
  - RUN: grants allowed. drain_req=1 -> DRAIN.
  - DRAIN: no grants; outstanding==0 -> DRAINED.
  - DRAINED: drain_done=1; drain_req=0 -> RUN.
- Grant eligible = state RUN && !c0tx_almfull && outstanding < MAX_OUTSTANDING.
- At most one grant per cycle. Only one valid: grant it. Both valid: grant the one indicated by RR pointer; pointer then points at the other requester. Pointer unchanged when no grant. Reset pointer = requester 0.
- rqN_ready is combinational from rqN_valid, eligibility, and pointer; never asserted without rqN_valid.
- On grant: register addr and {N, mdata} into c0tx_*; c0tx_valid=1 next cycle.
- outstanding: +1 on grant, -1 on c0rx_rspvalid, unchanged if both in the same cycle. Response at 0: counter stays 0, err_underflow sets (cleared only by reset).
- Response routing: c0rx_mdata[15] selects N; rspN_valid/mdata/data registered, 1-cycle latency; the other channel's valid stays 0.
- Requester must hold valid/addr/mdata stable until ready.

## Timing
- Reset values: all outputs 0 (rq ready, c0tx_*, rsp*, drain_done, outstanding, err_underflow, stats).
- Accept at cycle T -> c0tx_valid at T+1 (single-cycle pulse per grant). Back-to-back grants give consecutive c0tx_valid.
- almfull sampled in the grant cycle; an issue already registered still goes out at T+1 (within CCI-P almfull slack).
- Response at T -> rspN_valid at T+1.
- drain_req rising at T: no grant at T if state already registered as RUN? No — state updates at T+1; grants stop from T+1. drain_done asserts the cycle after outstanding reaches 0 in DRAIN.
- Reset mid-operation: counter, FSM, pointer, pipeline cleared next edge; in-flight responses arriving later count as underflow.

## Configuration
- C0_ARB_STATS_EN defined: statN_grants increment per grant to N; stat_stall increments each cycle where any rqN_valid=1 in RUN but eligibility is false; all saturate at 0xFFFF_FFFF.
- Undefined: counters not built; stat outputs tied to 0.

## Test plan
- Single requester: rq0 issues 4 addrs 0x100..0x103 back-to-back -> c0tx_valid 4 consecutive cycles, mdata[15]=0, outstanding=4; 4 responses -> rsp0_valid x4, outstanding=0.
- Contention: both valid continuously 6 cycles -> grants alternate 0,1,0,1,0,1; mdata[15] alternates accordingly.
- Backpressure: almfull=1 for 5 cycles with rq1 valid -> rq1_ready=0 throughout, stat_stall=5 (with macro); grant the cycle after almfull drops.
- Credit cap: MAX_OUTSTANDING=2, 3 requests, no responses -> third held; one response -> third granted next cycle; simultaneous grant+response keeps outstanding=2.
- Drain: 3 in flight, drain_req=1 -> no ready; after 3rd response drain_done=1; drain_req=0 -> RUN, grants resume.
- Underflow/reset: response with outstanding=0 -> err_underflow=1 sticky; softReset mid-burst -> all outputs 0 next cycle.
